// File: rtl/aes_core_sched.sv
// Two-requester round-robin scheduler in front of a single AES cipher core.
// Accepts one job at a time, drives the core, and returns the result or a timeout error.
`timescale 1ns/1ps

module aes_core_sched #(
  parameter int TIMEOUT = 32,
  parameter int NREQ    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [128*NREQ-1:0]    req_key,
  input  logic [128*NREQ-1:0]    req_text,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [127:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   core_ld,
  output logic [127:0]           core_key,
  output logic [127:0]           core_text,
  input  logic                   core_done,
  input  logic [127:0]           core_text_out,
  output logic                   busy,
  output logic                   owner
);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_t;

  localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [7:0]   timer_q, timer_d;
  logic         last_q, last_d;
  logic         owner_q, owner_d;
  logic [127:0] key_q, key_d;
  logic [127:0] text_q, text_d;
  logic [127:0] data_q, data_d;
  logic         err_q, err_d;
  logic         gnt;

  // last_q is the requester served most recently; resetting it to 1 favours requester 0.
  assign gnt = (req_valid == 2'b11) ? ~last_q : req_valid[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      key_q   <= '0;
      text_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      key_q   <= key_d;
      text_q  <= text_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    last_d    = last_q;
    owner_d   = owner_q;
    key_d     = key_q;
    text_d    = text_q;
    data_d    = data_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_valid = '0;
    core_ld   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = gnt ? 2'b10 : 2'b01;
          owner_d   = gnt;
          key_d     = gnt ? req_key[255:128]  : req_key[127:0];
          text_d    = gnt ? req_text[255:128] : req_text[127:0];
          state_d   = LOAD;
        end
      end
      LOAD: begin
        core_ld = 1'b1;
        timer_d = '0;
        state_d = BUSY;
      end
      BUSY: begin
        timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
        // A completion on the last allowed cycle still counts as a success.
        if (core_done) begin
          data_d  = core_text_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TimerLast) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        if (rsp_ready[owner_q]) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign core_key  = key_q;
  assign core_text = text_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_aes_core_sched.sv
// Directed bench for aes_core_sched: single job, round-robin contention, timeout,
// done/timeout race, response backpressure and reset during a job.
`timescale 1ns/1ps

module tb_aes_core_sched;

  localparam int TIMEOUT = 32;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] T0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] T1 = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [255:0] req_key;
  logic [255:0] req_text;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         core_ld;
  logic [127:0] core_key;
  logic [127:0] core_text;
  logic         core_done;
  logic [127:0] core_text_out;
  logic         busy;
  logic         owner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_core_sched #(.TIMEOUT(TIMEOUT), .NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_text(req_text),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_ld(core_ld), .core_key(core_key), .core_text(core_text),
    .core_done(core_done), .core_text_out(core_text_out),
    .busy(busy), .owner(owner)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0; core_done = 1'b0; core_text_out = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // Present v in IDLE, capture the combinational grant, and step into LOAD.
  task automatic accept(input logic [1:0] v, output logic [1:0] gnt);
    req_valid = v;
    #1;
    gnt = req_ready;
    cyc();
  endtask

  // From the LOAD cycle, count BUSY cycles until rsp_valid; pulse core_done on BUSY cycle doneAt.
  task automatic runBusy(input int doneAt, input logic [127:0] res,
                         output int nBusy, output bit sawBad);
    nBusy = 0; sawBad = 1'b0; core_text_out = res;
    for (int i = 0; i < 200; i++) begin
      cyc();
      core_done = 1'b0;
      if (rsp_valid != 2'b00) break;
      if (req_ready != 2'b00 || core_ld) sawBad = 1'b1;
      nBusy++;
      if (nBusy == doneAt) core_done = 1'b1;
    end
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if ({req_ready, rsp_valid, rsp_err, core_ld, busy, owner} !== 8'h00) begin errors++; $display("[TB] FAIL reset_ctrl got=%h exp=00", {req_ready, rsp_valid, rsp_err, core_ld, busy, owner}); end
    checks++; if (rsp_data !== 128'h0) begin errors++; $display("[TB] FAIL reset_data got=%h exp=0", rsp_data); end
    checks++; if ({core_key, core_text} !== 256'h0) begin errors++; $display("[TB] FAIL reset_core got=%h exp=0", {core_key, core_text}); end
  endtask

  task automatic test_contention();
    logic [1:0] g, expG;
    logic [127:0] res;
    int n;
    bit bad;
    doReset();
    for (int i = 0; i < 4; i++) begin
      expG = (i % 2 == 1) ? 2'b10 : 2'b01;
      res  = 128'hc0de0000 + 128'(i);
      accept(2'b11, g);
      checks++; if (g !== expG) begin errors++; $display("[TB] FAIL rr_grant%0d got=%b exp=%b", i, g, expG); end
      checks++; if (owner !== expG[1]) begin errors++; $display("[TB] FAIL rr_owner%0d got=%b exp=%b", i, owner, expG[1]); end
      runBusy(i + 1, res, n, bad);
      checks++; if (bad || n != i + 1) begin errors++; $display("[TB] FAIL rr_busy%0d got=%0d/%0d exp=%0d/0", i, n, bad, i + 1); end
      checks++; if ({rsp_valid, rsp_data} !== {expG, res}) begin errors++; $display("[TB] FAIL rr_rsp%0d got=%b/%h exp=%b/%h", i, rsp_valid, rsp_data, expG, res); end
      rsp_ready = expG;
      cyc();
      rsp_ready = '0;
    end
    req_valid = '0;
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    logic [1:0] g;
    int n;
    bit bad;
    accept(2'b01, g);
    req_valid = '0;
    checks++; if (g !== 2'b01) begin errors++; $display("[TB] FAIL single_grant got=%b exp=01", g); end
    checks++; if ({core_ld, req_ready, busy} !== 4'b1001) begin errors++; $display("[TB] FAIL single_load got=%b exp=1001", {core_ld, req_ready, busy}); end
    checks++; if ({core_key, core_text} !== {K0, T0}) begin errors++; $display("[TB] FAIL single_core got=%h exp=%h", {core_key, core_text}, {K0, T0}); end
    runBusy(1, C0, n, bad);
    checks++; if (bad || n != 1) begin errors++; $display("[TB] FAIL single_latency got=%0d/%0d exp=1/0", n, bad); end
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b0, C0}) begin errors++; $display("[TB] FAIL single_rsp got=%b/%b/%h exp=01/0/%h", rsp_valid, rsp_err, rsp_data, C0); end
    checks++; if (core_key !== K0) begin errors++; $display("[TB] FAIL single_keyhold got=%h exp=%h", core_key, K0); end
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = '0;
    checks++; if ({rsp_valid, busy} !== 3'b000) begin errors++; $display("[TB] FAIL single_done got=%b exp=000", {rsp_valid, busy}); end
  endtask

  task automatic test_timeout();
    logic [1:0] g;
    int n;
    bit bad;
    accept(2'b10, g);
    req_valid = '0;
    checks++; if ({g, owner, core_key} !== {3'b101, K1}) begin errors++; $display("[TB] FAIL to_grant got=%b/%b/%h exp=10/1/%h", g, owner, core_key, K1); end
    runBusy(0, 128'hdead, n, bad);
    checks++; if (bad || n != TIMEOUT) begin errors++; $display("[TB] FAIL to_cycles got=%0d/%0d exp=%0d/0", n, bad, TIMEOUT); end
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 1'b1, 128'h0}) begin errors++; $display("[TB] FAIL to_rsp got=%b/%b/%h exp=10/1/0", rsp_valid, rsp_err, rsp_data); end
    rsp_ready = 2'b10;
    cyc();
    rsp_ready = '0;
    accept(2'b01, g);
    req_valid = '0;
    runBusy(3, 128'h1234_5678, n, bad);
    checks++; if ({g, rsp_valid, rsp_err, rsp_data} !== {2'b01, 2'b01, 1'b0, 128'h1234_5678} || n != 3) begin errors++; $display("[TB] FAIL to_next got=%b/%b/%b/%h/%0d exp=01/01/0/12345678/3", g, rsp_valid, rsp_err, rsp_data, n); end
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = '0;
  endtask

  task automatic test_coincide();
    logic [1:0] g;
    int n;
    bit bad;
    accept(2'b01, g);
    req_valid = '0;
    runBusy(TIMEOUT, 128'hfeed_beef, n, bad);
    checks++; if (n != TIMEOUT) begin errors++; $display("[TB] FAIL race_cycles got=%0d exp=%0d", n, TIMEOUT); end
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b0, 128'hfeed_beef}) begin errors++; $display("[TB] FAIL race_rsp got=%b/%b/%h exp=01/0/feedbeef", rsp_valid, rsp_err, rsp_data); end
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = '0;
  endtask

  task automatic test_backpressure();
    logic [1:0] g;
    int n;
    bit bad;
    accept(2'b10, g);
    req_valid = '0;
    runBusy(2, 128'habcd, n, bad);
    req_valid = 2'b11;
    rsp_ready = 2'b01;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++; if ({rsp_valid, req_ready, rsp_err, rsp_data} !== {2'b10, 2'b00, 1'b0, 128'habcd}) begin errors++; $display("[TB] FAIL bp_hold%0d got=%b/%b/%b/%h exp=10/00/0/abcd", i, rsp_valid, req_ready, rsp_err, rsp_data); end
    end
    rsp_ready = 2'b10;
    req_valid = '0;
    cyc();
    rsp_ready = '0;
    checks++; if ({busy, rsp_valid} !== 3'b000) begin errors++; $display("[TB] FAIL bp_release got=%b exp=000", {busy, rsp_valid}); end
  endtask

  task automatic test_reset_busy();
    logic [1:0] g;
    int n;
    bit bad;
    accept(2'b01, g);
    req_valid = '0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    checks++; if ({req_ready, rsp_valid, rsp_err, core_ld, busy, owner, rsp_data, core_key, core_text} !== '0) begin errors++; $display("[TB] FAIL rb_reset got=%b/%b/%b/%b/%b/%b nonzero data/key/text=%b", req_ready, rsp_valid, rsp_err, core_ld, busy, owner, {rsp_data, core_key, core_text} != '0); end
    rst = 1'b0;
    core_done = 1'b1;
    core_text_out = 128'h5555;
    cyc();
    core_done = 1'b0;
    cyc();
    checks++; if ({rsp_valid, busy} !== 3'b000) begin errors++; $display("[TB] FAIL rb_late_done got=%b exp=000", {rsp_valid, busy}); end
    accept(2'b01, g);
    req_valid = '0;
    checks++; if ({g, core_ld, core_key} !== {3'b011, K0}) begin errors++; $display("[TB] FAIL rb_regrant got=%b/%b/%h exp=01/1/%h", g, core_ld, core_key, K0); end
    runBusy(1, C0, n, bad);
    checks++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b0, C0}) begin errors++; $display("[TB] FAIL rb_rsp got=%b/%b/%h exp=01/0/%h", rsp_valid, rsp_err, rsp_data, C0); end
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = '0;
  endtask

  initial begin
    req_key  = {K1, K0};
    req_text = {T1, T0};
    test_reset();
    test_contention();
    test_single();
    test_timeout();
    test_coincide();
    test_backpressure();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
